// File: rtl/bin2bcd_if.sv
// bin2bcd_if: request/result bundle between the calculator datapath and the BCD converter.
interface bin2bcd_if #(parameter int WIDTH = 16, parameter int DIGITS = 5);
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                neg;
  logic [DIGITS-1:0]   blank;
  modport master (output start, bin, input busy, done, bcd, neg, blank);
  modport slave  (input start, bin, output busy, done, bcd, neg, blank);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter producing BCD digits, sign and leading-zero blank mask.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1
) (
  input logic clk,
  input logic rst,
  bin2bcd_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  if (64'(10) ** DIGITS < (64'(1) << WIDTH)) begin : g_bad
    $error("DIGITS too small to hold every WIDTH-bit magnitude");
  end
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  mag_q, mag_d;
  logic [BW-1:0]     scr_q, scr_d, adj, nxt, bcd_q, bcd_d;
  logic              sign_q, sign_d, neg_q, neg_d, done_q, done_d, z;
  logic [DIGITS-1:0] blank_q, blank_d, fin_blank;
  always_comb begin
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = scr_q[4*i+:4] >= 4'd5 ? scr_q[4*i+:4] + 4'd3 : scr_q[4*i+:4];
    nxt = {adj[BW-2:0], mag_q[WIDTH-1]};
    // A digit is blank only if it and every more significant digit are zero.
    fin_blank = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      z = z & (nxt[4*i+:4] == 4'd0);
      fin_blank[i] = z;
    end
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    blank_d = blank_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        sign_d  = SIGNED && bus.bin[WIDTH-1];
        mag_d   = sign_d ? ~bus.bin + WIDTH'(1) : bus.bin;
        scr_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
    end else begin
      scr_d = nxt;
      mag_d = {mag_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        bcd_d   = nxt;
        neg_d   = sign_q;
        blank_d = fin_blank;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      scr_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      blank_q <= blank_d;
      done_q  <= done_d;
    end
  end
  assign bus.busy  = state_q == SHIFT;
  assign bus.done  = done_q;
  assign bus.bcd   = bcd_q;
  assign bus.neg   = neg_q;
  assign bus.blank = blank_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed plus random checks of signed and unsigned converters against a decimal model.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_done = -1;
  bin2bcd_if #(.WIDTH(16), .DIGITS(5)) si ();
  bin2bcd_if #(.WIDTH(16), .DIGITS(5)) ui ();
  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .bus(si.slave));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) dut_u (.clk(clk), .rst(rst), .bus(ui.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [19:0] ref_bcd(input int unsigned m);
    logic [19:0] r;
    for (int i = 0; i < 5; i++) begin
      r[4*i+:4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_blank(input int unsigned m);
    logic [4:0] b;
    int unsigned p = 1;
    b = '0;
    for (int i = 1; i < 5; i++) begin
      p = p * 10;
      b[i] = m < p;
    end
    return b;
  endfunction

  function automatic logic digits_ok(input logic [19:0] d);
    logic ok = 1'b1;
    for (int i = 0; i < 5; i++) ok = ok & (d[4*i+:4] <= 4'd9);
    return ok;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input logic [15:0] v);
    int unsigned ms;
    ms = v[15] ? 65536 - int'(v) : int'(v);
    chk("u_bcd", 32'(ui.bcd), 32'(ref_bcd(int'(v))));
    chk("u_neg", 32'(ui.neg), 0);
    chk("u_blank", 32'(ui.blank), 32'(ref_blank(int'(v))));
    chk("u_digits", 32'(digits_ok(ui.bcd)), 1);
    chk("s_bcd", 32'(si.bcd), 32'(ref_bcd(ms)));
    chk("s_neg", 32'(si.neg), 32'(v[15]));
    chk("s_blank", 32'(si.blank), 32'(ref_blank(ms)));
    chk("s_digits", 32'(digits_ok(si.bcd)), 1);
  endtask

  // Starts a conversion on the current cycle; optionally re-pulses start (bin=9999) while busy.
  task automatic run(input logic [15:0] v, input int intr);
    int lat, bc;
    si.start = 1'b1; ui.start = 1'b1; si.bin = v; ui.bin = v;
    @(posedge clk); #1;
    si.start = 1'b0; ui.start = 1'b0;
    si.bin = 16'($urandom); ui.bin = si.bin;
    lat = 0; bc = 0;
    while (!si.done && lat < 40) begin
      bc += int'(si.busy);
      si.start = (lat == intr); ui.start = si.start;
      if (lat == intr) begin si.bin = 16'd9999; ui.bin = 16'd9999; end
      @(posedge clk); #1; lat++;
    end
    si.start = 1'b0; ui.start = 1'b0;
    chk("latency", 32'(lat), 16);
    chk("busy_cycles", 32'(bc), 16);
    chk("u_done", 32'(ui.done), 1);
    chk("busy_at_done", 32'(si.busy), 0);
    if (last_done >= 0) chk("done_spacing", 32'(cyc - last_done >= 17), 1);
    last_done = cyc;
    check_res(v);
  endtask

  initial begin
    logic seen;
    si.start = 1'b0; ui.start = 1'b0; si.bin = '0; ui.bin = '0;
    #12;
    chk("rst_busy", 32'(si.busy), 0);
    chk("rst_done", 32'(si.done), 0);
    chk("rst_bcd", 32'(si.bcd), 0);
    chk("rst_neg", 32'(si.neg), 0);
    chk("rst_blank", 32'(si.blank), 32'b11110);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    run(16'd0, -1);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(si.done), 0);
    run(16'hFFFF, -1);
    run(16'h8000, -1);
    run(16'hFFF9, -1);
    run(16'd1234, 5);
    chk("ignored_start_bcd", 32'(si.bcd), 32'h01234);
    run(16'd9999, -1);
    chk("done_cycle_start_bcd", 32'(si.bcd), 32'h09999);
    @(posedge clk); #1;
    chk("no_extra_done", 32'(si.done | ui.done), 0);
    si.start = 1'b1; ui.start = 1'b1; si.bin = 16'd777; ui.bin = 16'd777;
    @(posedge clk); #1;
    si.start = 1'b0; ui.start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(si.busy | ui.busy), 0);
    chk("abort_done", 32'(si.done | ui.done), 0);
    chk("abort_bcd", 32'(si.bcd | ui.bcd), 0);
    chk("abort_blank", 32'(si.blank), 32'b11110);
    #2 rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      seen = seen | si.done | ui.done;
    end
    chk("abort_no_done", 32'(seen), 0);
    last_done = -1;
    run(16'd4321, -1);
    for (int n = 0; n < 1000; n++) run(16'($urandom), -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
